// File: rtl/vert_pkg.sv
// Shared types and helpers for the vertex transform block: FSM state
// encoding, fixed-point fraction derivation, index width and the saturating
// screen-coordinate adder.
package vert_pkg;

    localparam int ANGLE_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CALC,
        EMIT
    } state_t;

    // sin/cos use two integer bits (sign plus one), the rest is fraction.
    function automatic int frac_bits(input int trig_w);
        return trig_w - 2;
    endfunction

    // Width of a vertex index; a single-vertex batch still needs one bit.
    function automatic int idx_width(input int num_verts);
        return (num_verts > 1) ? $clog2(num_verts) : 1;
    endfunction

    // base + delta clamped to [0, hi].
    function automatic int sat_add(input int base, input int delta, input int hi);
        int s;
        s = base + delta;
        if (s < 0) begin
            s = 0;
        end else if (s > hi) begin
            s = hi;
        end
        return s;
    endfunction

endpackage

// File: rtl/vert_transform_if.sv
// Screen-space vertex stream from vert_transform to triangle setup.
// Optional macro VERT_TRANSFORM_DEPTH_EN adds the signed depth field out_z.
interface vert_transform_if #(
    parameter int SCREEN_W = 10,
    parameter int IDX_W    = 2
`ifdef VERT_TRANSFORM_DEPTH_EN
   ,parameter int COORD_W  = 8
`endif
);

    logic                out_valid;
    logic                out_ready;
    logic [SCREEN_W-1:0] out_x;
    logic [SCREEN_W-1:0] out_y;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;
`ifdef VERT_TRANSFORM_DEPTH_EN
    logic signed [COORD_W:0] out_z;

    modport master (output out_valid, out_x, out_y, out_idx, out_last, out_z,
                    input  out_ready);
    modport slave  (input  out_valid, out_x, out_y, out_idx, out_last, out_z,
                    output out_ready);
`else
    modport master (output out_valid, out_x, out_y, out_idx, out_last,
                    input  out_ready);
    modport slave  (input  out_valid, out_x, out_y, out_idx, out_last,
                    output out_ready);
`endif

endinterface

// File: rtl/vert_transform_angle_ticker.sv
// Free-running rotation angle: a prescaler of TICK_DIV pixel clocks per step
// and an angle that wraps from ANGLE_MAX back to zero.
module angle_ticker
    import vert_pkg::*;
#(
    parameter int TICK_DIV  = 333334,
    parameter int ANGLE_MAX = 359
) (
    input  logic               clk_pix,
    input  logic               resetn,
    output logic [ANGLE_W-1:0] live_angle
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt;

    // Prescaler and angle step; the angle only moves on prescaler wrap.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            tick_cnt   <= '0;
            live_angle <= '0;
        end else if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
            tick_cnt   <= '0;
            live_angle <= (live_angle == ANGLE_W'(ANGLE_MAX)) ? '0
                                                               : live_angle + ANGLE_W'(1);
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vert_transform.sv
// Y-axis vertex rotation and screen mapping. One batch of NUM_VERTS vertices
// is fetched, transformed and streamed per accepted frame_start.
// Optional macro VERT_TRANSFORM_DEPTH_EN adds the rotated depth out_z.
module vert_transform
    import vert_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int TRIG_W    = 12,
    parameter int SCREEN_W  = 10,
    parameter int NUM_VERTS = 3,
    parameter int CENTER_X  = 320,
    parameter int CENTER_Y  = 240,
    parameter int TICK_DIV  = 333334,
    parameter int ANGLE_MAX = 359
) (
    input  logic                                clk_pix,
    input  logic                                resetn,
    input  logic                                frame_start,
    output logic [ANGLE_W-1:0]                  angle,
    input  logic signed [TRIG_W-1:0]            sin,
    input  logic signed [TRIG_W-1:0]            cos,
    output logic [idx_width(NUM_VERTS)-1:0]     vert_addr,
    input  logic signed [COORD_W-1:0]           vert_x,
    input  logic signed [COORD_W-1:0]           vert_y,
    input  logic signed [COORD_W-1:0]           vert_z,
    vert_transform_if.master                    stream,
    output logic                                busy,
    output logic                                overrun
);

    localparam int FRAC       = frac_bits(TRIG_W);
    localparam int PROD_W     = COORD_W + TRIG_W;
    localparam int SUM_W      = PROD_W + 1;
    localparam int IDX_W      = idx_width(NUM_VERTS);
    localparam int SCREEN_MAX = (2 ** SCREEN_W) - 1;

    logic [ANGLE_W-1:0] live_angle;
    state_t             state;
    logic [IDX_W-1:0]   idx;

    angle_ticker #(
        .TICK_DIV  (TICK_DIV),
        .ANGLE_MAX (ANGLE_MAX)
    ) u_ticker (
        .clk_pix    (clk_pix),
        .resetn     (resetn),
        .live_angle (live_angle)
    );

    // Rotated X: operands are sign-extended to the full product width so the
    // multiply is exact, then summed one bit wider to absorb the carry.
    logic signed [PROD_W-1:0] x_cos;
    logic signed [PROD_W-1:0] z_sin;
    logic signed [SUM_W-1:0]  x_sum;

    assign x_cos = PROD_W'(vert_x) * PROD_W'(cos);
    assign z_sin = PROD_W'(vert_z) * PROD_W'(sin);
    assign x_sum = {x_cos[PROD_W-1], x_cos} + {z_sin[PROD_W-1], z_sin};

`ifdef VERT_TRANSFORM_DEPTH_EN
    // Rotated Z for depth: z*cos - x*sin.
    logic signed [PROD_W-1:0] z_cos;
    logic signed [PROD_W-1:0] x_sin;
    logic signed [SUM_W-1:0]  z_sum;

    assign z_cos = PROD_W'(vert_z) * PROD_W'(cos);
    assign x_sin = PROD_W'(vert_x) * PROD_W'(sin);
    assign z_sum = {z_cos[PROD_W-1], z_cos} - {x_sin[PROD_W-1], x_sin};
`endif

    // Batch sequencer with registered outputs; ROM data arrives in CALC,
    // one cycle after FETCH drives the address.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            idx              <= '0;
            angle            <= '0;
            vert_addr        <= '0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_x     <= '0;
            stream.out_y     <= '0;
            stream.out_idx   <= '0;
            stream.out_last  <= 1'b0;
`ifdef VERT_TRANSFORM_DEPTH_EN
            stream.out_z     <= '0;
`endif
        end else begin
            // NOTE: overrun is defaulted low every cycle so it can only ever
            // be a one-cycle pulse; any later assignment in this block wins.
            overrun <= 1'b0;
            if (frame_start && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        angle     <= live_angle;
                        idx       <= '0;
                        vert_addr <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end

                FETCH: begin
                    state <= CALC;
                end

                CALC: begin
                    stream.out_x     <= SCREEN_W'(sat_add(CENTER_X, int'(x_sum >>> FRAC),
                                                          SCREEN_MAX));
                    stream.out_y     <= SCREEN_W'(sat_add(CENTER_Y, -int'(vert_y),
                                                          SCREEN_MAX));
`ifdef VERT_TRANSFORM_DEPTH_EN
                    stream.out_z     <= (COORD_W + 1)'(int'(z_sum >>> FRAC));
`endif
                    stream.out_idx   <= idx;
                    stream.out_last  <= (idx == IDX_W'(NUM_VERTS - 1));
                    stream.out_valid <= 1'b1;
                    state            <= EMIT;
                end

                EMIT: begin
                    if (stream.out_ready) begin
                        stream.out_valid <= 1'b0;
                        if (stream.out_last) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx       <= idx + IDX_W'(1);
                            vert_addr <= idx + IDX_W'(1);
                            state     <= FETCH;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vert_transform.sv
// Self-checking bench for vert_transform. Two instances run in lockstep on
// the same stimulus: one with the default screen centre, one with
// CENTER_X=0 / CENTER_Y=1000 to reach both saturation rails.
module tb_vert_transform;

    localparam int NV     = 3;
    localparam int IW     = 2;
    localparam int TICK   = 4;
    localparam int AMAX   = 359;
    localparam int CX_A   = 320;
    localparam int CY_A   = 240;
    localparam int CX_B   = 0;
    localparam int CY_B   = 1000;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic              resetn;
    logic              frame_start;
    logic              ready;
    logic signed [11:0] sin_v;
    logic signed [11:0] cos_v;

    logic [8:0]        angle_a, angle_b;
    logic [IW-1:0]     addr_a, addr_b;
    logic signed [7:0] vx_a, vy_a, vz_a;
    logic signed [7:0] vx_b, vy_b, vz_b;
    logic              busy_a, busy_b, ovr_a, ovr_b;

    logic signed [7:0] rom_x [NV];
    logic signed [7:0] rom_y [NV];
    logic signed [7:0] rom_z [NV];

`ifdef VERT_TRANSFORM_DEPTH_EN
    vert_transform_if #(.SCREEN_W(10), .IDX_W(IW), .COORD_W(8)) bus_a ();
    vert_transform_if #(.SCREEN_W(10), .IDX_W(IW), .COORD_W(8)) bus_b ();
`else
    vert_transform_if #(.SCREEN_W(10), .IDX_W(IW)) bus_a ();
    vert_transform_if #(.SCREEN_W(10), .IDX_W(IW)) bus_b ();
`endif

    assign bus_a.out_ready = ready;
    assign bus_b.out_ready = ready;

    vert_transform #(
        .NUM_VERTS(NV), .CENTER_X(CX_A), .CENTER_Y(CY_A),
        .TICK_DIV(TICK), .ANGLE_MAX(AMAX)
    ) dut_a (
        .clk_pix(clk_pix), .resetn(resetn), .frame_start(frame_start),
        .angle(angle_a), .sin(sin_v), .cos(cos_v), .vert_addr(addr_a),
        .vert_x(vx_a), .vert_y(vy_a), .vert_z(vz_a), .stream(bus_a),
        .busy(busy_a), .overrun(ovr_a)
    );

    vert_transform #(
        .NUM_VERTS(NV), .CENTER_X(CX_B), .CENTER_Y(CY_B),
        .TICK_DIV(TICK), .ANGLE_MAX(AMAX)
    ) dut_b (
        .clk_pix(clk_pix), .resetn(resetn), .frame_start(frame_start),
        .angle(angle_b), .sin(sin_v), .cos(cos_v), .vert_addr(addr_b),
        .vert_x(vx_b), .vert_y(vy_b), .vert_z(vz_b), .stream(bus_b),
        .busy(busy_b), .overrun(ovr_b)
    );

    // Vertex ROMs with one cycle of read latency.
    always @(posedge clk_pix) begin
        vx_a <= rom_x[addr_a]; vy_a <= rom_y[addr_a]; vz_a <= rom_z[addr_a];
        vx_b <= rom_x[addr_b]; vy_b <= rom_y[addr_b]; vz_b <= rom_z[addr_b];
    end

    // Clock edges seen out of reset; the live angle is floor(cyc/TICK) mod 360.
    int cyc;
    always @(posedge clk_pix or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clamp_scr(input int v);
        if (v < 0)    return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    function automatic int floor_frac(input int p);
        return int'($floor(real'(p) / 1024.0));
    endfunction

    int ex_a [NV], ey_a [NV], ex_b [NV], ey_b [NV], ez [NV];

    task automatic model_expected();
        for (int i = 0; i < NV; i++) begin
            int x, y, z, c, s, xr, zr;
            x = int'(rom_x[i]); y = int'(rom_y[i]); z = int'(rom_z[i]);
            c = int'(cos_v);    s = int'(sin_v);
            xr = floor_frac(x * c + z * s);
            zr = floor_frac(z * c - x * s);
            ex_a[i] = clamp_scr(CX_A + xr);
            ey_a[i] = clamp_scr(CY_A - y);
            ex_b[i] = clamp_scr(CX_B + xr);
            ey_b[i] = clamp_scr(CY_B - y);
            ez[i]   = ((zr % 512) + 512 + 256) % 512 - 256;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_vertex(input int v);
        check("valid_a", int'(bus_a.out_valid), 1);
        check("idx_a",   int'(bus_a.out_idx), v);
        check("last_a",  int'(bus_a.out_last), (v == NV - 1) ? 1 : 0);
        check("x_a",     int'(bus_a.out_x), ex_a[v]);
        check("y_a",     int'(bus_a.out_y), ey_a[v]);
        check("valid_b", int'(bus_b.out_valid), 1);
        check("x_b",     int'(bus_b.out_x), ex_b[v]);
        check("y_b",     int'(bus_b.out_y), ey_b[v]);
`ifdef VERT_TRANSFORM_DEPTH_EN
        check("z_a",     int'(bus_a.out_z), ez[v]);
        check("z_b",     int'(bus_b.out_z), ez[v]);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, int'(bus_a.out_valid), 0);
        check({tag, "_x"},     int'(bus_a.out_x), 0);
        check({tag, "_y"},     int'(bus_a.out_y), 0);
        check({tag, "_idx"},   int'(bus_a.out_idx), 0);
        check({tag, "_last"},  int'(bus_a.out_last), 0);
        check({tag, "_busy"},  int'(busy_a), 0);
        check({tag, "_ovr"},   int'(ovr_a), 0);
        check({tag, "_angle"}, int'(angle_a), 0);
        check({tag, "_addr"},  int'(addr_a), 0);
        check({tag, "_y_b"},   int'(bus_b.out_y), 0);
    endtask

    // One batch. stall_v/stall_n hold out_ready low for extra cycles on one
    // vertex. ovr_mode 1: frame_start pulsed while vertex stall_v is held;
    // ovr_mode 2: frame_start coincident with the final handshake.
    task automatic run_batch(input int stall_v, input int stall_n, input int ovr_mode);
        int k, wait_n, exp_ang;
        @(negedge clk_pix);
        k = cyc;
        exp_ang = (k / TICK) % (AMAX + 1);
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
        check("busy_start", int'(busy_a), 1);
        check("angle_a", int'(angle_a), exp_ang);
        check("angle_b", int'(angle_b), exp_ang);
        for (int v = 0; v < NV; v++) begin
            wait_n = 0;
            while (!bus_a.out_valid && wait_n < 20) begin
                @(negedge clk_pix);
                wait_n++;
            end
            check("latency", wait_n, 2);
            check_vertex(v);
            if (v == stall_v) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk_pix);
                    check_vertex(v);
                end
                if (ovr_mode == 1) begin
                    frame_start = 1'b1;
                    @(negedge clk_pix);
                    frame_start = 1'b0;
                    check("ovr_pulse_a", int'(ovr_a), 1);
                    check("ovr_pulse_b", int'(ovr_b), 1);
                    check("ovr_angle", int'(angle_a), exp_ang);
                    check_vertex(v);
                    @(negedge clk_pix);
                    check("ovr_one_cycle", int'(ovr_a), 0);
                end
            end
            ready = 1'b1;
            if (ovr_mode == 2 && v == NV - 1) frame_start = 1'b1;
            @(negedge clk_pix);
            ready = 1'b0;
            frame_start = 1'b0;
            check("valid_drop_a", int'(bus_a.out_valid), 0);
            check("valid_drop_b", int'(bus_b.out_valid), 0);
            if (ovr_mode == 2 && v == NV - 1) check("ovr_last_hs", int'(ovr_a), 1);
        end
        check("busy_end", int'(busy_a), 0);
        if (ovr_mode == 2) begin
            repeat (4) @(negedge clk_pix);
            check("no_relaunch_busy", int'(busy_a), 0);
            check("no_relaunch_valid", int'(bus_a.out_valid), 0);
        end else begin
            check("ovr_idle", int'(ovr_a), 0);
        end
    endtask

    task automatic wait_cyc_mod(input int target);
        int n = 0;
        while ((cyc % (TICK * (AMAX + 1))) != target && n < 3000) begin
            @(negedge clk_pix);
            n++;
        end
        check("wait_cyc_bound", (n < 3000) ? 1 : 0, 1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int x, y, z, c, s;
        int xa, ya, xb, yb, zr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{x:  50, y:   20, z:   30, c: 1024, s:    0, xa: 370, ya: 220, xb:  50, yb:  980, zr:  30};
        vecs[1] = '{x:  50, y:    0, z:  -30, c:    0, s: 1024, xa: 290, ya: 240, xb:   0, yb: 1000, zr: -50};
        vecs[2] = '{x: -40, y: -127, z:    0, c: 1024, s:    0, xa: 280, ya: 367, xb:   0, yb: 1023, zr:   0};
        vecs[3] = '{x: 127, y:  127, z:  127, c: 2047, s: 2047, xa: 827, ya: 113, xb: 507, yb:  873, zr:   0};
        vecs[4] = '{x:-128, y: -128, z: -128, c: 2047, s: 2047, xa:   0, ya: 368, xb:   0, yb: 1023, zr:   0};
        vecs[5] = '{x:  10, y:    5, z:   -7, c:-1024, s:    0, xa: 310, ya: 235, xb:   0, yb:  995, zr:   7};
        vecs[6] = '{x:   1, y:    0, z:    0, c:   -1, s:    0, xa: 319, ya: 240, xb:   0, yb: 1000, zr:   0};
        vecs[7] = '{x:   3, y:    1, z:    0, c:    0, s:    1, xa: 320, ya: 239, xb:   0, yb:  999, zr:  -1};

        resetn = 1'b0; frame_start = 1'b0; ready = 1'b0;
        sin_v = 12'sd0; cos_v = 12'sd1024;
        for (int i = 0; i < NV; i++) begin
            rom_x[i] = '0; rom_y[i] = '0; rom_z[i] = '0;
        end
        #12;
        check_reset_state("rst_init");
        @(negedge clk_pix);
        resetn = 1'b1;

        // Directed table; vector 0 also carries a 5-cycle stall on vertex 1.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NV; i++) begin
                rom_x[i] = 8'(vecs[t].x); rom_y[i] = 8'(vecs[t].y); rom_z[i] = 8'(vecs[t].z);
                ex_a[i] = vecs[t].xa; ey_a[i] = vecs[t].ya;
                ex_b[i] = vecs[t].xb; ey_b[i] = vecs[t].yb;
                ez[i]   = vecs[t].zr;
            end
            sin_v = 12'(vecs[t].s);
            cos_v = 12'(vecs[t].c);
            run_batch((t == 0) ? 1 : -1, (t == 0) ? 5 : 0, 0);
        end

        // Randomized batches against the model.
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < NV; i++) begin
                rom_x[i] = 8'(int'($urandom_range(0, 255)) - 128);
                rom_y[i] = 8'(int'($urandom_range(0, 255)) - 128);
                rom_z[i] = 8'(int'($urandom_range(0, 255)) - 128);
            end
            sin_v = 12'(int'($urandom_range(0, 4095)) - 2048);
            cos_v = 12'(int'($urandom_range(0, 4095)) - 2048);
            model_expected();
            run_batch(int'($urandom_range(0, NV - 1)), int'($urandom_range(0, 4)),
                      (r == 3) ? 1 : ((r == 7) ? 2 : 0));
        end

        // Angle wrap: launch with live angle 359, then again just past the wrap.
        sin_v = 12'sd0; cos_v = 12'sd1024;
        model_expected();
        wait_cyc_mod(TICK * AMAX - 1);
        run_batch(-1, 0, 0);
        check("angle_at_max", int'(angle_a), AMAX);
        wait_cyc_mod(TICK * (AMAX + 1) - 1);
        run_batch(-1, 0, 0);
        check("angle_wrapped", int'(angle_a), 0);

        // Reset mid-batch while vertex 1 is on the bus.
        for (int i = 0; i < NV; i++) begin
            rom_x[i] = 8'(20 + i); rom_y[i] = 8'(-5 - i); rom_z[i] = 8'(0);
        end
        model_expected();
        wait_cyc_mod(TICK * 100);
        @(negedge clk_pix);
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
        for (int v = 0; v < 2; v++) begin
            int n = 0;
            while (!bus_a.out_valid && n < 20) begin
                @(negedge clk_pix);
                n++;
            end
            check("pre_rst_idx", int'(bus_a.out_idx), v);
            if (v == 0) begin
                ready = 1'b1;
                @(negedge clk_pix);
                ready = 1'b0;
            end
        end
        #2 resetn = 1'b0;
        #1 check_reset_state("rst_mid");
        @(negedge clk_pix);
        resetn = 1'b1;
        run_batch(-1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
